// File: rtl/pipeline_ctrl_if.sv
// Command handshake between the debug front-end and pipeline_ctrl.
// The front-end is the master; the sequencer answers with cmd_ready.
interface pipeline_ctrl_if;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_code,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_code,
    output cmd_ready
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Run/step/halt sequencer for the 5-stage pipeline.
// Gates PC/latch enables, drains after HALT and counts enabled cycles.
module pipeline_ctrl #(
  parameter logic [5:0] HALT_OPCODE  = 6'b111111,
  parameter int         DRAIN_CYCLES = 4,
  parameter int         CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_ctrl_if.slave       cmd,
  input  logic [31:0]          id_instruction,
  output logic                 pc_en,
  output logic                 pipe_en,
  output logic                 nop_inject,
  output logic                 pipe_flush,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int DW = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  localparam logic [1:0] CMD_RUN   = 2'b00;
  localparam logic [1:0] CMD_STEP  = 2'b01;
  localparam logic [1:0] CMD_PAUSE = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    DRAIN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [DW-1:0] drain;
  logic [DW-1:0] drain_d;
  logic          flush_q;
  logic          clr;
  logic          fire;
  logic          halt_hit;

  assign pc_en      = (state == RUN) || (state == STEP);
  assign pipe_en    = pc_en || (state == DRAIN);
  assign nop_inject = (state == DRAIN);
  assign busy       = pipe_en;
  assign done       = (state == DONE);
  assign pipe_flush = flush_q;

  assign cmd.cmd_ready = (state == IDLE)
                      || (state == RUN)
                      || (state == DONE);

  assign fire     = cmd.cmd_valid && cmd.cmd_ready;
  assign halt_hit = (id_instruction[31:26] == HALT_OPCODE)
                 && pipe_en;

  always_comb begin
    state_d = state;
    drain_d = drain;
    clr     = 1'b0;
    unique case (state)
      IDLE: begin
        if (fire) begin
          unique case (cmd.cmd_code)
            CMD_RUN:   state_d = RUN;
            CMD_STEP:  state_d = STEP;
            CMD_CLEAR: clr = 1'b1;
            default:   ;
          endcase
        end
      end
      RUN: begin
        // HALT wins; a simultaneous command is consumed and dropped
        if (halt_hit) begin
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (fire && cmd.cmd_code == CMD_PAUSE) begin
          state_d = IDLE;
        end else if (fire && cmd.cmd_code == CMD_CLEAR) begin
          state_d = IDLE;
          clr     = 1'b1;
        end
      end
      STEP: begin
        if (halt_hit) begin
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (drain == '0) state_d = DONE;
        else drain_d = drain - DW'(1);
      end
      DONE: begin
        if (fire && cmd.cmd_code == CMD_CLEAR) begin
          state_d = IDLE;
          clr     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      drain       <= '0;
      flush_q     <= 1'b0;
      cycle_count <= '0;
    end else begin
      state   <= state_d;
      drain   <= drain_d;
      flush_q <= clr;
      if (clr) begin
        cycle_count <= '0;
      end else if (pipe_en && !(&cycle_count)) begin
        cycle_count <= cycle_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios then random
// commands/instructions against a behavioural model.
module tb_pipeline_ctrl;

  localparam int CW   = 5;
  localparam int MAXC = (1 << CW) - 1;

  typedef logic [CW+6:0] obs_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   instr;
  logic          pc_en;
  logic          pipe_en;
  logic          nop_inject;
  logic          pipe_flush;
  logic          busy;
  logic          done;
  logic [CW-1:0] cnt;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(
    .CNT_WIDTH(CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd            (bus),
    .id_instruction (instr),
    .pc_en          (pc_en),
    .pipe_en        (pipe_en),
    .nop_inject     (nop_inject),
    .pipe_flush     (pipe_flush),
    .busy           (busy),
    .done           (done),
    .cycle_count    (cnt)
  );

  always #5 clk = ~clk;

  obs_t obs;
  assign obs = {pc_en, pipe_en, nop_inject, pipe_flush,
                busy, done, bus.cmd_ready, cnt};

  obs_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // behavioural model
  bit running;
  bit stepping;
  bit finished;
  bit flush;
  int drain_left;
  int count;

  function automatic obs_t expect_now();
    bit pe;
    pe = running || stepping || (drain_left > 0);
    return {running || stepping, pe, drain_left > 0, flush,
            pe, finished, !stepping && drain_left == 0,
            CW'(count)};
  endfunction

  task automatic model_step(input bit r, input bit v,
                            input logic [1:0] code,
                            input logic [31:0] ins);
    bit pe;
    bit fire;
    bit halt;
    if (r) begin
      running = 0; stepping = 0; finished = 0;
      drain_left = 0; flush = 0; count = 0;
      return;
    end
    pe   = running || stepping || (drain_left > 0);
    fire = v && !stepping && drain_left == 0;
    halt = pe && ins[31:26] == 6'h3f;
    flush = 0;
    if (pe && count < MAXC) count++;
    if (drain_left > 0) begin
      drain_left--;
      if (drain_left == 0) finished = 1;
    end else if (halt) begin
      running = 0; stepping = 0; drain_left = 4;
    end else if (stepping) begin
      stepping = 0;
    end else if (fire) begin
      case (code)
        2'd0: if (!running && !finished) running = 1;
        2'd1: if (!running && !finished) stepping = 1;
        2'd2: running = 0;
        2'd3: begin
          running = 0; finished = 0; count = 0; flush = 1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check(input string name, input obs_t act,
                       input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t actual=%b required=%b",
               name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) check("cycle", obs, expq.pop_front());
  end

  function automatic logic [31:0] nh();
    return {6'($urandom_range(0, 62)), 26'($urandom)};
  endfunction

  function automatic logic [31:0] hl();
    return {6'h3f, 26'($urandom)};
  endfunction

  task automatic cyc(input bit r, input bit v,
                     input logic [1:0] code,
                     input logic [31:0] ins);
    @(negedge clk);
    #1;
    reset         = r;
    bus.cmd_valid = v;
    bus.cmd_code  = code;
    instr         = ins;
    model_step(r, v, code, ins);
    expq.push_back(expect_now());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 2'd0, nh());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = 2'd0;
    instr = 32'h0;
    model_step(1, 0, 2'd0, 32'h0);
    #2;
    check("reset_state", obs, expect_now());
    cyc(1, 0, 2'd0, nh());
    cyc(1, 0, 2'd0, nh());
    idle(2);

    // run 10 cycles then pause
    cyc(0, 1, 2'd0, nh());
    idle(9);
    cyc(0, 1, 2'd2, nh());
    idle(3);

    // three single steps
    cyc(0, 1, 2'd3, nh());
    idle(2);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 2'd1, nh());
      idle(3);
    end

    // halt reaches ID on the 6th run cycle
    cyc(0, 1, 2'd3, nh());
    idle(1);
    cyc(0, 1, 2'd0, nh());
    idle(5);
    cyc(0, 0, 2'd0, hl());
    idle(8);
    // clear out of DONE
    cyc(0, 1, 2'd3, nh());
    idle(3);

    // halt and pause on the same edge
    cyc(0, 1, 2'd0, nh());
    idle(3);
    cyc(0, 1, 2'd2, hl());
    idle(8);
    cyc(0, 1, 2'd3, nh());
    idle(2);

    // halt during a step, commands while draining
    cyc(0, 1, 2'd1, nh());
    cyc(0, 0, 2'd0, hl());
    cyc(0, 1, 2'd3, nh());
    cyc(0, 1, 2'd0, hl());
    idle(5);
    cyc(0, 1, 2'd0, nh());
    cyc(0, 1, 2'd3, nh());
    idle(2);

    // counter saturation
    cyc(0, 1, 2'd0, nh());
    idle(40);
    cyc(0, 1, 2'd2, nh());
    idle(2);
    cyc(0, 1, 2'd3, nh());
    idle(2);

    // asynchronous reset while the drain counter reads 2
    cyc(0, 1, 2'd0, nh());
    cyc(0, 0, 2'd0, hl());
    cyc(0, 0, 2'd0, nh());
    @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_step(1, 0, 2'd0, 32'h0);
    check("async_reset", obs, expect_now());
    cyc(1, 0, 2'd0, nh());
    idle(6);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 9) < 3,
          2'($urandom_range(0, 3)),
          ($urandom_range(0, 15) == 0) ? hl() : nh());
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0",
               expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
